// File: rtl/bit_scan_engine.sv
// bit_scan_engine: self-sequenced bit-scan datapath.
// Loads an operand into y and walks index s over it with a programmable
// stride and direction, folding each visited bit b = y[s] into an accumulator.
// Modes: COUNT (popcount), FIRST (lowest set index), LAST (highest set index),
// SUMIDX (sum of indices of set bits, mod 2^WIDTH).
//
// Handshake: start is sampled only when busy=0 (state IDLE). An accepted start
// latches x, mode and step. busy stays high from the edge that accepted start
// until the scan has finished. done is a one-cycle pulse that is raised on the
// first cycle back in IDLE; result and found are valid from that cycle and hold
// until the next accepted start. A start during that done cycle is accepted.
module bit_scan_engine #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [$clog2(WIDTH)-1:0]  step,
    input  logic [WIDTH-1:0]          x,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH-1:0]          result,
    output logic                      found,
    output logic [WIDTH-1:0]          y,
    output logic [$clog2(WIDTH)-1:0]  s,
    output logic                      b
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW:0]   MAX_IDX = (IW+1)'(WIDTH - 1);
    localparam logic [1:0]    M_COUNT  = 2'd0;
    localparam logic [1:0]    M_FIRST  = 2'd1;
    localparam logic [1:0]    M_LAST   = 2'd2;
    localparam logic [1:0]    M_SUMIDX = 2'd3;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q;
    logic [IW-1:0]   st;
    logic [WIDTH-1:0] acc;
    logic            hit;
    logic [IW:0]     next_idx;
    logic            is_search;
    logic            hit_now;
    logic            end_of_scan;

    assign b         = y[s];
    assign busy      = (state_q != IDLE);
    assign is_search = (mode_q == M_FIRST) || (mode_q == M_LAST);
    // Ascending next index is one bit wider so overrun is visible instead of wrapping.
    assign next_idx  = {1'b0, s} + {1'b0, st};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic, including terminating-hit and end-of-range detection.
    always_comb begin
        state_d     = state_q;
        hit_now     = 1'b0;
        end_of_scan = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = SCAN;
            SCAN: begin
                hit_now = is_search && b;
                if (mode_q == M_LAST) end_of_scan = (st > s);
                else                  end_of_scan = (next_idx > MAX_IDX);
                if (hit_now || end_of_scan) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand/index registers, accumulator, and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            y      <= '0;
            s      <= '0;
            mode_q <= M_COUNT;
            st     <= '0;
            acc    <= '0;
            hit    <= 1'b0;
            result <= '0;
            found  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        y      <= x;
                        mode_q <= mode;
                        st     <= (step == '0) ? IW'(1) : step;
                        acc    <= '0;
                        hit    <= 1'b0;
                        s      <= (mode == M_LAST) ? IW'(WIDTH - 1) : '0;
                    end
                end
                SCAN: begin
                    case (mode_q)
                        M_COUNT:  acc <= acc + WIDTH'(b);
                        M_SUMIDX: if (b) acc <= acc + WIDTH'(s);
                        default: begin
                            if (b) begin
                                acc <= WIDTH'(s);
                                hit <= 1'b1;
                            end
                        end
                    endcase
                    // s stays on the last visited position once the scan ends.
                    if (!(hit_now || end_of_scan)) begin
                        if (mode_q == M_LAST) s <= s - st;
                        else                  s <= next_idx[IW-1:0];
                    end
                end
                DONE: begin
                    result <= acc;
                    found  <= is_search ? hit : (acc != '0);
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_scan_engine.sv
// tb_bit_scan_engine: directed vectors with hand-computed expectations for an
// 8-bit and a 16-bit instance of bit_scan_engine.
module tb_bit_scan_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [1:0]  mode;
    logic [3:0]  step;
    logic [15:0] x;

    logic        busy8, done8, found8, b8;
    logic [7:0]  result8, y8;
    logic [2:0]  s8;
    logic        busy16, done16, found16, b16;
    logic [15:0] result16, y16;
    logic [3:0]  s16;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];

    // Selected-instance views used by the run task.
    bit          sel = 1'b0;
    logic        busy_m, done_m, found_m, b_m;
    logic [15:0] result_m, y_m;
    logic [3:0]  s_m;
    assign busy_m   = sel ? busy16   : busy8;
    assign done_m   = sel ? done16   : done8;
    assign found_m  = sel ? found16  : found8;
    assign b_m      = sel ? b16      : b8;
    assign result_m = sel ? result16 : {8'h00, result8};
    assign y_m      = sel ? y16      : {8'h00, y8};
    assign s_m      = sel ? s16      : {1'b0, s8};

    bit_scan_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode), .step(step[2:0]),
        .x(x[7:0]), .busy(busy8), .done(done8), .result(result8),
        .found(found8), .y(y8), .s(s8), .b(b8)
    );

    bit_scan_engine #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .mode(mode), .step(step),
        .x(x), .busy(busy16), .done(done16), .result(result16),
        .found(found16), .y(y16), .s(s16), .b(b16)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Launch one scan and follow it to done. Optionally compares s against
    // exp_q every busy cycle, and optionally pulses start mid-scan with new data.
    task automatic run_scan(input bit use16, input logic [1:0] m, input logic [3:0] st,
                            input logic [15:0] xv, input logic [15:0] er, input bit ef,
                            input int elat, input bit chk_s, input bit mid_pulse);
        int edges;
        int busy_cnt;
        bit bcheck_ok;
        sel = use16;
        @(negedge clk);
        mode = m; step = st; x = xv;
        if (use16) start16 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        edges = 0; busy_cnt = 0; bcheck_ok = 1'b1;
        while (!done_m && edges < 100) begin
            if (busy_m) begin
                busy_cnt++;
                if (b_m !== y_m[s_m]) bcheck_ok = 1'b0;
                if (chk_s) begin
                    if (exp_q.size() == 0) check("s_extra", {28'h0, s_m}, 32'hFFFF);
                    else check("s_seq", {28'h0, s_m}, {28'h0, exp_q.pop_front()});
                end
            end
            if (mid_pulse && edges == 1) begin
                if (use16) start16 = 1'b1; else start8 = 1'b1;
                x = 16'hFFFF; mode = 2'd3; step = 4'd1;
            end else begin
                start8 = 1'b0; start16 = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        start8 = 1'b0; start16 = 1'b0;
        check("latency", edges, elat);
        check("busy_cycles", busy_cnt, elat);
        check("b_tracks_y_s", {31'h0, bcheck_ok}, 32'h1);
        check("result", {16'h0, result_m}, {16'h0, er});
        check("found", {31'h0, found_m}, {31'h0, ef});
        if (chk_s) check("s_left", exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_pulse_len", {31'h0, done_m}, 32'h0);
        check("result_hold", {16'h0, result_m}, {16'h0, er});
    endtask

    initial begin
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0; mode = 2'd0; step = 4'd0; x = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {31'h0, busy8}, 32'h0);
        check("rst_done", {31'h0, done8}, 32'h0);
        check("rst_result", {24'h0, result8}, 32'h0);
        check("rst_found", {31'h0, found8}, 32'h0);
        check("rst_y", {24'h0, y8}, 32'h0);
        check("rst_s", {29'h0, s8}, 32'h0);
        check("rst_busy16", {31'h0, busy16}, 32'h0);

        // COUNT 0xB5: five set bits, 8 positions visited.
        run_scan(1'b0, 2'd0, 4'd1, 16'h00B5, 16'd5, 1'b1, 9, 1'b0, 1'b0);
        // FIRST 0x28: hit at 3.
        for (int i = 0; i < 4; i++) exp_q.push_back(4'(i));
        exp_q.push_back(4'd3);
        run_scan(1'b0, 2'd1, 4'd1, 16'h0028, 16'd3, 1'b1, 5, 1'b1, 1'b0);
        // FIRST 0x00: no hit.
        run_scan(1'b0, 2'd1, 4'd1, 16'h0000, 16'd0, 1'b0, 9, 1'b0, 1'b0);
        // LAST 0x28: visits 7,6,5.
        exp_q.push_back(4'd7); exp_q.push_back(4'd6); exp_q.push_back(4'd5); exp_q.push_back(4'd5);
        run_scan(1'b0, 2'd2, 4'd1, 16'h0028, 16'd5, 1'b1, 4, 1'b1, 1'b0);
        // SUMIDX 0xFF step 2: 0+2+4+6.
        exp_q.push_back(4'd0); exp_q.push_back(4'd2); exp_q.push_back(4'd4);
        exp_q.push_back(4'd6); exp_q.push_back(4'd6);
        run_scan(1'b0, 2'd3, 4'd2, 16'h00FF, 16'd12, 1'b1, 5, 1'b1, 1'b0);
        // SUMIDX 0xFF step 3: 0+3+6.
        exp_q.push_back(4'd0); exp_q.push_back(4'd3); exp_q.push_back(4'd6); exp_q.push_back(4'd6);
        run_scan(1'b0, 2'd3, 4'd3, 16'h00FF, 16'd9, 1'b1, 4, 1'b1, 1'b0);
        // LAST 0x01 step 3: visits 7,4,1 then stops before wrapping; no hit.
        exp_q.push_back(4'd7); exp_q.push_back(4'd4); exp_q.push_back(4'd1); exp_q.push_back(4'd1);
        run_scan(1'b0, 2'd2, 4'd3, 16'h0001, 16'd0, 1'b0, 4, 1'b1, 1'b0);
        // COUNT 0xB5 with a start pulse mid-scan: ignored.
        run_scan(1'b0, 2'd0, 4'd1, 16'h00B5, 16'd5, 1'b1, 9, 1'b0, 1'b1);

        // Reset three cycles into a scan aborts without done.
        sel = 1'b0;
        @(negedge clk);
        mode = 2'd0; step = 4'd1; x = 16'h00FF; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'h0, busy8}, 32'h0);
        check("abort_result", {24'h0, result8}, 32'h0);
        check("abort_done", {31'h0, done8}, 32'h0);
        begin
            bit saw_done = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (done8) saw_done = 1'b1;
            end
            check("abort_no_done", {31'h0, saw_done}, 32'h0);
        end
        run_scan(1'b0, 2'd0, 4'd1, 16'h0001, 16'd1, 1'b1, 9, 1'b0, 1'b0);

        // 16-bit COUNT, step 0 treated as stride 1.
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        exp_q.push_back(4'd15);
        run_scan(1'b1, 2'd0, 4'd0, 16'hFFFF, 16'd16, 1'b1, 17, 1'b1, 1'b0);
        // 16-bit SUMIDX 0x8001: 0 + 15.
        run_scan(1'b1, 2'd3, 4'd1, 16'h8001, 16'd15, 1'b1, 17, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
